// File: rtl/adf4159_pkg.sv
// Shared types and default timeouts for the ADF4159 load sequencer.
package adf4159_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WAIT_FREE    = 3'd1,
        ST_LOAD         = 3'd2,
        ST_WAIT_BUSY_LO = 3'd3,
        ST_WAIT_LOCK    = 3'd4,
        ST_DONE         = 3'd5
    } seq_state_e;

    localparam int unsigned DEF_BUSY_TO_CYC = 4096;
    localparam int unsigned DEF_LOCK_TO_CYC = 65535;

endpackage

// File: rtl/adf4159_load_seq_timeout.sv
// Saturating wait-cycle counter; expired is high on the limit-th enabled cycle after clear.
// Registered count, combinational expired; clear takes priority over enable.
module seq_timeout #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    localparam logic [W:0] ONE = (W+1)'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // cnt_q counts cycles already spent, so the current cycle is number cnt_q+1
    assign expired = ({1'b0, cnt_q} + ONE) >= {1'b0, limit};

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/adf4159_load_seq.sv
// Multi-channel synthesizer load sequencer: waits free, pulses load until busy, waits busy low
// (and lock when ADF4159_LOAD_SEQ_LOCK_WAIT_EN is defined); per-state timeouts report failing channels.
module adf4159_load_seq
    import adf4159_pkg::*;
#(
    parameter int unsigned NUM_CH      = 6,
    parameter int unsigned BUSY_TO_CYC = DEF_BUSY_TO_CYC,
    parameter int unsigned LOCK_TO_CYC = DEF_LOCK_TO_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [NUM_CH-1:0] trig_mask,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] lock,
    output logic [NUM_CH-1:0] load,
    output logic              seq_busy,
    output logic              done,
    output logic [NUM_CH-1:0] err_mask,
    output logic              pending
);

    localparam int unsigned TO_MAX = (BUSY_TO_CYC > LOCK_TO_CYC) ? BUSY_TO_CYC : LOCK_TO_CYC;
    localparam int unsigned TO_W   = $clog2(TO_MAX + 1);

    seq_state_e        state_q, state_d;
    logic [NUM_CH-1:0] act_mask_q, act_mask_d;
    logic [NUM_CH-1:0] err_mask_q, err_mask_d;
    logic [NUM_CH-1:0] pend_mask_q, pend_mask_d;
    logic              pending_q, pending_d;

    logic              to_en;
    logic              to_expired;
    logic [TO_W-1:0]   to_limit;
    logic [NUM_CH-1:0] busy_act;
    logic [NUM_CH-1:0] next_mask;

    assign busy_act = busy & act_mask_q;

    always_comb begin
        state_d     = state_q;
        act_mask_d  = act_mask_q;
        err_mask_d  = err_mask_q;
        pend_mask_d = pend_mask_q;
        pending_d   = pending_q;
        to_en       = 1'b0;
        to_limit    = TO_W'(BUSY_TO_CYC);
        next_mask   = pend_mask_q | (trig ? trig_mask : '0);

        if (state_q != ST_IDLE && trig) begin
            pend_mask_d = pend_mask_q | trig_mask;
            pending_d   = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    act_mask_d = trig_mask;
                    err_mask_d = '0;
                    state_d    = (trig_mask != '0) ? ST_WAIT_FREE : ST_DONE;
                end
            end
            ST_WAIT_FREE: begin
                to_en = 1'b1;
                if (busy_act == '0) begin
                    state_d = ST_LOAD;
                end else if (to_expired) begin
                    err_mask_d = busy_act;
                    state_d    = ST_DONE;
                end
            end
            ST_LOAD: begin
                to_en = 1'b1;
                if (busy_act == act_mask_q) begin
                    state_d = ST_WAIT_BUSY_LO;
                end else if (to_expired) begin
                    err_mask_d = act_mask_q & ~busy;
                    state_d    = ST_DONE;
                end
            end
            ST_WAIT_BUSY_LO: begin
                to_en = 1'b1;
                if (busy_act == '0) begin
`ifdef ADF4159_LOAD_SEQ_LOCK_WAIT_EN
                    state_d = ST_WAIT_LOCK;
`else
                    state_d = ST_DONE;
`endif
                end else if (to_expired) begin
                    err_mask_d = busy_act;
                    state_d    = ST_DONE;
                end
            end
            // Only entered when the lock wait is compiled in
            ST_WAIT_LOCK: begin
                to_en    = 1'b1;
                to_limit = TO_W'(LOCK_TO_CYC);
                if ((lock & act_mask_q) == act_mask_q) begin
                    state_d = ST_DONE;
                end else if (to_expired) begin
                    err_mask_d = act_mask_q & ~lock;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                // A trig landing in this cycle joins whatever was already queued
                if (pending_q || trig) begin
                    pend_mask_d = '0;
                    pending_d   = 1'b0;
                    err_mask_d  = '0;
                    act_mask_d  = next_mask;
                    state_d     = (next_mask != '0) ? ST_WAIT_FREE : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            act_mask_q  <= '0;
            err_mask_q  <= '0;
            pend_mask_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_mask_q  <= act_mask_d;
            err_mask_q  <= err_mask_d;
            pend_mask_q <= pend_mask_d;
            pending_q   <= pending_d;
        end
    end

    seq_timeout #(
        .W (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .enable  (to_en),
        .limit   (to_limit),
        .expired (to_expired)
    );

    assign load     = (state_q == ST_LOAD) ? act_mask_q : '0;
    assign seq_busy = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err_mask = err_mask_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_adf4159_load_seq.sv
// Scoreboarded bench for adf4159_load_seq: expected per-sequence results queued at trig, checked at done.
module tb_adf4159_load_seq;

    localparam int NUM_CH = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              trig;
    logic [NUM_CH-1:0] trig_mask;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] lock;
    logic [NUM_CH-1:0] load;
    logic              seq_busy;
    logic              done;
    logic [NUM_CH-1:0] err_mask;
    logic              pending;

    adf4159_load_seq dut (
        .clk       (clk),
        .rst       (rst),
        .trig      (trig),
        .trig_mask (trig_mask),
        .busy      (busy),
        .lock      (lock),
        .load      (load),
        .seq_busy  (seq_busy),
        .done      (done),
        .err_mask  (err_mask),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] err;
        logic [NUM_CH-1:0] ld;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: accumulate load activity per sequence, compare at each done pulse
    logic [NUM_CH-1:0] load_acc = '0;
    int                load_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            load_acc = '0;
            load_cyc = 0;
        end else begin
            load_acc = load_acc | load;
            if (load != '0) load_cyc++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_err_mask", 32'(err_mask), 32'(e.err));
                    chk("sb_load_mask", 32'(load_acc), 32'(e.ld));
                    if (e.cyc >= 0) chk("sb_load_cycles", 32'(load_cyc), 32'(e.cyc));
                end
                load_acc = '0;
                load_cyc = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NUM_CH-1:0] err, input logic [NUM_CH-1:0] ld, input int cyc);
        exp_t e;
        e.err = err;
        e.ld  = ld;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic fire(input logic [NUM_CH-1:0] m);
        trig      = 1'b1;
        trig_mask = m;
        tick();
        trig      = 1'b0;
        trig_mask = '0;
    endtask

    task automatic wait_load(input int max);
        int n = 0;
        while (load == '0 && n < max) begin
            tick();
            n++;
        end
        chk("load_seen", 32'(load != '0), 32'd1);
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    int n;

    initial begin
        rst       = 1'b0;
        trig      = 1'b0;
        trig_mask = '0;
        busy      = '0;
        lock      = '1;
        repeat (3) tick();
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_seq_busy", 32'(seq_busy), 32'd0);
        chk("rst_err_mask", 32'(err_mask), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        rst = 1'b1;
        tick();

        // Nominal two-channel load: busy rises 2 cycles into load, falls 50 later
        push(6'b000000, 6'b000011, 3);
        fire(6'b000011);
        wait_load(20);
        tick();
        tick();
        busy = 6'b000011;
        repeat (50) tick();
        busy = '0;
        wait_done(100, n);
        chk("nom_err_mask", 32'(err_mask), 32'd0);
        tick();
        chk("nom_idle", 32'(seq_busy), 32'd0);

        // Channel 5 never frees: WAIT_FREE timeout
        busy = 6'b100000;
        push(6'b100000, 6'b000000, 0);
        fire(6'b100000);
        wait_done(5000, n);
        chk("wf_timeout_cycles", 32'(n), 32'd4096);
        busy = '0;
        repeat (3) tick();
        chk("err_hold", 32'(err_mask), 32'h20);

        // Lock wait on channel 2 with lock[2] stuck low
        lock = 6'b111011;
`ifdef ADF4159_LOAD_SEQ_LOCK_WAIT_EN
        push(6'b000100, 6'b000100, 1);
`else
        push(6'b000000, 6'b000100, 1);
`endif
        fire(6'b000100);
        chk("err_clr_on_start", 32'(err_mask), 32'd0);
        wait_load(20);
        busy = 6'b000100;
        tick();
        busy = '0;
        tick();
        wait_done(70000, n);
`ifdef ADF4159_LOAD_SEQ_LOCK_WAIT_EN
        chk("lock_timeout_cycles", 32'(n), 32'd65535);
        chk("lock_err_mask", 32'(err_mask), 32'h04);
`else
        chk("lock_ignored_cycles", 32'(n), 32'd0);
        chk("lock_ignored_err", 32'(err_mask), 32'd0);
`endif
        lock = '1;
        tick();

        // Queued requests: one mid-sequence, one in the DONE cycle, merged into one sequence
        push(6'b000000, 6'b000100, 1);
        push(6'b000000, 6'b000011, 1);
        fire(6'b000100);
        wait_load(20);
        busy = 6'b000100;
        tick();
        busy = '0;
        fire(6'b000001);
        chk("pend_set", 32'(pending), 32'd1);
        wait_done(20, n);
        chk("pend_in_done", 32'(pending), 32'd1);
        fire(6'b000010);
        chk("pend_no_idle", 32'(seq_busy), 32'd1);
        chk("pend_done_low", 32'(done), 32'd0);
        chk("pend_cleared", 32'(pending), 32'd0);
        wait_load(20);
        chk("pend_act_mask", 32'(load), 32'h03);
        busy = 6'b000011;
        tick();
        busy = '0;
        wait_done(20, n);
        tick();

        // Reset while in LOAD: load drops, no done pulse
        fire(6'b000011);
        wait_load(20);
        rst = 1'b0;
        tick();
        chk("rst_mid_load", 32'(load), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_idle", 32'(seq_busy), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_mid_done2", 32'(done), 32'd0);
        chk("rst_mid_pend", 32'(pending), 32'd0);

        // Empty mask: straight to DONE
        push(6'b000000, 6'b000000, 0);
        fire(6'b000000);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_load", 32'(load), 32'd0);
        tick();
        chk("zero_done_once", 32'(done), 32'd0);
        chk("zero_idle", 32'(seq_busy), 32'd0);

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
